// File: rtl/swipt_po_tuner.sv
// rtl/swipt_po_tuner.sv - perturb-and-observe frequency/duty tuner for the SWIPT H-bridge driver
module swipt_po_tuner #(
    parameter logic [19:0] F_INIT     = 20'd100000,
    parameter logic [19:0] F_MIN      = 20'd80000,
    parameter logic [19:0] F_MAX      = 20'd150000,
    parameter logic [19:0] F_STEP     = 20'd1000,
    parameter logic [11:0] L_INIT     = 12'd480,
    parameter logic [11:0] L_MIN      = 12'd100,
    parameter logic [11:0] L_MAX      = 12'd490,
    parameter logic [11:0] L_STEP     = 12'd10,
    parameter int          RELOAD_CYC = 4,
    parameter logic [15:0] SETTLE_CYC = 16'd5000,
    parameter int          REV_LIMIT  = 3,
    parameter logic [15:0] DROP_TH    = 16'd64
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en,
    input  logic        meas_valid,
    input  logic [15:0] meas_power,
    output logic [19:0] freq,
    output logic [11:0] l,
    output logic        drv_nrst,
    output logic        axis,
    output logic        locked,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_APPLY, S_SETTLE, S_MEASURE, S_DECIDE, S_LOCKED
    } state_t;

    localparam logic [15:0] RELOAD_LAST = 16'(RELOAD_CYC - 1);
    localparam logic [15:0] SETTLE_LAST = SETTLE_CYC - 16'd1;
    localparam logic [3:0]  REV_MAX     = 4'(REV_LIMIT);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [19:0] freq_q, freq_d;
    logic [11:0] l_q, l_d;
    logic        drv_nrst_q, drv_nrst_d;
    logic        axis_q, axis_d;
    logic        locked_q, locked_d;
    logic        dir_q, dir_d;
    logic [3:0]  rev_cnt_q, rev_cnt_d;
    logic [15:0] prev_power_q, prev_power_d;
    logic [15:0] lock_power_q, lock_power_d;
    logic        first_q, first_d;
    logic [15:0] sample_q, sample_d;

    logic        dir_n;
    logic [3:0]  rev_n;
    logic [20:0] f_up, f_dn;
    logic [12:0] l_up, l_dn;
    logic        f_hi, f_lo, l_hi, l_lo, drop;

    assign freq     = freq_q;
    assign l        = l_q;
    assign drv_nrst = drv_nrst_q;
    assign axis     = axis_q;
    assign locked   = locked_q;
    assign busy     = (state_q != S_IDLE) && (state_q != S_LOCKED);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 16'd0;
            freq_q       <= F_INIT;
            l_q          <= L_INIT;
            drv_nrst_q   <= 1'b0;
            axis_q       <= 1'b0;
            locked_q     <= 1'b0;
            dir_q        <= 1'b1;
            rev_cnt_q    <= 4'd0;
            prev_power_q <= 16'd0;
            lock_power_q <= 16'd0;
            first_q      <= 1'b1;
            sample_q     <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            freq_q       <= freq_d;
            l_q          <= l_d;
            drv_nrst_q   <= drv_nrst_d;
            axis_q       <= axis_d;
            locked_q     <= locked_d;
            dir_q        <= dir_d;
            rev_cnt_q    <= rev_cnt_d;
            prev_power_q <= prev_power_d;
            lock_power_q <= lock_power_d;
            first_q      <= first_d;
            sample_q     <= sample_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        freq_d       = freq_q;
        l_d          = l_q;
        drv_nrst_d   = drv_nrst_q;
        axis_d       = axis_q;
        locked_d     = locked_q;
        dir_d        = dir_q;
        rev_cnt_d    = rev_cnt_q;
        prev_power_d = prev_power_q;
        lock_power_d = lock_power_q;
        first_d      = first_q;
        sample_d     = sample_q;
        dir_n        = dir_q;
        rev_n        = rev_cnt_q;

        // One extra bit so a step past either bound is visible before saturating
        f_up = {1'b0, freq_q} + {1'b0, F_STEP};
        f_dn = {1'b0, freq_q} - {1'b0, F_STEP};
        l_up = {1'b0, l_q} + {1'b0, L_STEP};
        l_dn = {1'b0, l_q} - {1'b0, L_STEP};
        f_hi = f_up > {1'b0, F_MAX};
        f_lo = f_dn[20] || (f_dn < {1'b0, F_MIN});
        l_hi = l_up > {1'b0, L_MAX};
        l_lo = l_dn[12] || (l_dn < {1'b0, L_MIN});
        drop = meas_valid && (({1'b0, meas_power} + {1'b0, DROP_TH}) < {1'b0, lock_power_q});

        case (state_q)
            S_IDLE: begin
                drv_nrst_d = 1'b0;
                if (en) begin
                    state_d = S_APPLY;
                    cnt_d   = 16'd0;
                end
            end
            S_APPLY: begin
                drv_nrst_d = 1'b0;
                if (cnt_q == RELOAD_LAST) begin
                    state_d    = S_SETTLE;
                    cnt_d      = 16'd0;
                    drv_nrst_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_MEASURE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_MEASURE: begin
                if (meas_valid) begin
                    sample_d = meas_power;
                    state_d  = S_DECIDE;
                end
            end
            S_DECIDE: begin
                prev_power_d = sample_q;
                if (first_q) begin
                    first_d = 1'b0;
                end else if (sample_q < prev_power_q) begin
                    dir_n = ~dir_q;
                    rev_n = rev_cnt_q + 4'd1;
                end
                if ((rev_n == REV_MAX) && axis_q) begin
                    state_d      = S_LOCKED;
                    locked_d     = 1'b1;
                    lock_power_d = sample_q;
                    rev_cnt_d    = rev_n;
                    dir_d        = dir_n;
                end else begin
                    state_d    = S_APPLY;
                    cnt_d      = 16'd0;
                    drv_nrst_d = 1'b0;
                    if (rev_n == REV_MAX) begin
                        // Frequency converged: start the duty axis fresh, one step up
                        axis_d    = 1'b1;
                        rev_cnt_d = 4'd0;
                        first_d   = 1'b1;
                        if (l_hi) begin
                            l_d   = L_MAX;
                            dir_d = 1'b0;
                        end else begin
                            l_d   = l_up[11:0];
                            dir_d = 1'b1;
                        end
                    end else begin
                        rev_cnt_d = rev_n;
                        dir_d     = dir_n;
                        if (!axis_q) begin
                            if (dir_n) begin
                                if (f_hi) begin
                                    freq_d = F_MAX;
                                    dir_d  = 1'b0;
                                end else begin
                                    freq_d = f_up[19:0];
                                end
                            end else if (f_lo) begin
                                freq_d = F_MIN;
                                dir_d  = 1'b1;
                            end else begin
                                freq_d = f_dn[19:0];
                            end
                        end else begin
                            if (dir_n) begin
                                if (l_hi) begin
                                    l_d   = L_MAX;
                                    dir_d = 1'b0;
                                end else begin
                                    l_d = l_up[11:0];
                                end
                            end else if (l_lo) begin
                                l_d   = L_MIN;
                                dir_d = 1'b1;
                            end else begin
                                l_d = l_dn[11:0];
                            end
                        end
                    end
                end
            end
            S_LOCKED: begin
                drv_nrst_d = 1'b1;
                if (drop) begin
                    locked_d  = 1'b0;
                    axis_d    = 1'b0;
                    rev_cnt_d = 4'd0;
                    first_d   = 1'b1;
                    dir_d     = 1'b1;
                    state_d   = S_MEASURE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Disable wins over everything the state logic decided this cycle
        if (!en) begin
            state_d    = S_IDLE;
            cnt_d      = 16'd0;
            freq_d     = freq_q;
            l_d        = l_q;
            drv_nrst_d = 1'b0;
            locked_d   = 1'b0;
            axis_d     = 1'b0;
            rev_cnt_d  = 4'd0;
            first_d    = 1'b1;
            dir_d      = 1'b1;
        end
    end

endmodule

// File: tb/tb_swipt_po_tuner.sv
// tb/tb_swipt_po_tuner.sv - self-checking bench for swipt_po_tuner
module tb_swipt_po_tuner;

    logic        clk = 1'b0;
    logic        nrst;
    logic        en_v     [3];
    logic        mv_v     [3];
    logic [15:0] mp_v     [3];
    logic [19:0] freq_v   [3];
    logic [11:0] l_v      [3];
    logic        drv_v    [3];
    logic        axis_v   [3];
    logic        locked_v [3];
    logic        busy_v   [3];
    int          settle_n [3] = '{5000, 40, 40};

    int total = 0;
    int bad   = 0;

    int m_freq, m_l, m_dir, m_rev, m_prev, m_first, m_axis, m_locked, m_lockp;
    int pend;

    always #5 clk = ~clk;

    swipt_po_tuner u_dut (
        .clk(clk), .nrst(nrst), .en(en_v[0]), .meas_valid(mv_v[0]), .meas_power(mp_v[0]),
        .freq(freq_v[0]), .l(l_v[0]), .drv_nrst(drv_v[0]), .axis(axis_v[0]),
        .locked(locked_v[0]), .busy(busy_v[0])
    );

    swipt_po_tuner #(.SETTLE_CYC(16'd40)) u_fast (
        .clk(clk), .nrst(nrst), .en(en_v[1]), .meas_valid(mv_v[1]), .meas_power(mp_v[1]),
        .freq(freq_v[1]), .l(l_v[1]), .drv_nrst(drv_v[1]), .axis(axis_v[1]),
        .locked(locked_v[1]), .busy(busy_v[1])
    );

    swipt_po_tuner #(.F_INIT(20'd148000), .SETTLE_CYC(16'd40)) u_clamp (
        .clk(clk), .nrst(nrst), .en(en_v[2]), .meas_valid(mv_v[2]), .meas_power(mp_v[2]),
        .freq(freq_v[2]), .l(l_v[2]), .drv_nrst(drv_v[2]), .axis(axis_v[2]),
        .locked(locked_v[2]), .busy(busy_v[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: tuning rules stated directly on integer frequency/duty values
    task automatic model_reset(input int f_init);
        m_freq = f_init; m_l = 480; m_dir = 1; m_rev = 0; m_prev = 0;
        m_first = 1; m_axis = 0; m_locked = 0; m_lockp = 0; pend = 0;
    endtask

    task automatic model_en_drop();
        m_axis = 0; m_rev = 0; m_first = 1; m_dir = 1; m_locked = 0;
    endtask

    task automatic model_move_l(input int d);
        int t;
        t = m_l + d * 10;
        m_dir = d;
        if (t > 490) begin t = 490; m_dir = -d; end
        if (t < 100) begin t = 100; m_dir = -d; end
        m_l = t;
    endtask

    task automatic model_decide(input int s);
        int t;
        if (m_first != 0) m_first = 0;
        else if (s < m_prev) begin m_dir = -m_dir; m_rev++; end
        m_prev = s;
        if (m_rev == 3 && m_axis == 1) begin
            m_locked = 1;
            m_lockp  = s;
        end else if (m_rev == 3) begin
            m_axis = 1; m_rev = 0; m_first = 1;
            model_move_l(1);
        end else if (m_axis == 0) begin
            t = m_freq + m_dir * 1000;
            if (t > 150000) begin t = 150000; m_dir = -m_dir; end
            if (t < 80000)  begin t = 80000;  m_dir = -m_dir; end
            m_freq = t;
        end else begin
            model_move_l(m_dir);
        end
    endtask

    function automatic int pw_peak(input int f);
        int d;
        d = f - 110000;
        if (d < 0) d = -d;
        return 2000 - d / 100;
    endfunction

    task automatic do_reset();
        nrst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en_v[i] = 1'b0; mv_v[i] = 1'b0; mp_v[i] = 16'd0;
        end
        tick();
        tick();
        nrst = 1'b1;
    endtask

    task automatic wait_meas(input int i, input string tag);
        int n;
        n = 0;
        while (drv_v[i] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (drv_v[i] !== 1'b1) begin
            bad++;
            $display("FAIL %s: drv_nrst never released, got %b want 1", tag, drv_v[i]);
        end
        repeat (settle_n[i]) tick();
    endtask

    task automatic pulse_check(input int i, input int s, input string tag);
        mp_v[i] = 16'(s);
        mv_v[i] = 1'b1;
        tick();
        mv_v[i] = 1'b0;
        model_decide(s);
        tick();
        total++;
        if (freq_v[i] !== 20'(m_freq) || l_v[i] !== 12'(m_l) || axis_v[i] !== 1'(m_axis) ||
            locked_v[i] !== 1'(m_locked) || drv_v[i] !== 1'(m_locked)) begin
            bad++;
            $display("FAIL %s: got freq=%0d l=%0d axis=%0d locked=%0d drv=%0d want freq=%0d l=%0d axis=%0d locked=%0d drv=%0d",
                     tag, freq_v[i], l_v[i], axis_v[i], locked_v[i], drv_v[i],
                     m_freq, m_l, m_axis, m_locked, m_locked);
        end
    endtask

    task automatic pulse_locked(input int i, input int s, input string tag);
        mp_v[i] = 16'(s);
        mv_v[i] = 1'b1;
        tick();
        mv_v[i] = 1'b0;
        if (s + 64 < m_lockp) begin
            model_en_drop();
            pend = 1;
        end
        total++;
        if (locked_v[i] !== 1'(m_locked) || axis_v[i] !== 1'(m_axis) ||
            busy_v[i] !== 1'(1 - m_locked) || drv_v[i] !== 1'b1 || freq_v[i] !== 20'(m_freq)) begin
            bad++;
            $display("FAIL %s: got locked=%0d axis=%0d busy=%0d drv=%0d freq=%0d want locked=%0d axis=%0d busy=%0d drv=1 freq=%0d",
                     tag, locked_v[i], axis_v[i], busy_v[i], drv_v[i], freq_v[i],
                     m_locked, m_axis, 1 - m_locked, m_freq);
        end
    endtask

    task automatic test_reset();
        do_reset();
        repeat (20) tick();
        total++;
        if (freq_v[0] !== 20'd100000 || l_v[0] !== 12'd480 || drv_v[0] !== 1'b0 ||
            busy_v[0] !== 1'b0 || locked_v[0] !== 1'b0 || axis_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got freq=%0d l=%0d drv=%0d busy=%0d locked=%0d axis=%0d want 100000 480 0 0 0 0",
                     freq_v[0], l_v[0], drv_v[0], busy_v[0], locked_v[0], axis_v[0]);
        end
        total++;
        if (freq_v[2] !== 20'd148000 || l_v[2] !== 12'd480) begin
            bad++;
            $display("FAIL reset_finit: got freq=%0d l=%0d want 148000 480", freq_v[2], l_v[2]);
        end
    endtask

    task automatic test_apply_settle();
        int low_ok;
        model_reset(100000);
        en_v[0] = 1'b1;
        tick();
        total++;
        if (busy_v[0] !== 1'b1 || drv_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL apply_entry: got busy=%0d drv=%0d want 1 0", busy_v[0], drv_v[0]);
        end
        low_ok = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (drv_v[0] !== 1'b0) low_ok = 0;
        end
        total++;
        if (low_ok != 1) begin
            bad++;
            $display("FAIL reload_low: got drv released early want low 4 cycles");
        end
        tick();
        total++;
        if (drv_v[0] !== 1'b1) begin
            bad++;
            $display("FAIL reload_release: got drv=%0d want 1", drv_v[0]);
        end
        repeat (100) tick();
        mp_v[0] = 16'd1; mv_v[0] = 1'b1;
        tick();
        mv_v[0] = 1'b0;
        repeat (5000 - 1 - 101) tick();
        mp_v[0] = 16'd2; mv_v[0] = 1'b1;
        tick();
        mv_v[0] = 1'b0;
        tick();
        tick();
        total++;
        if (drv_v[0] !== 1'b1 || freq_v[0] !== 20'd100000 || busy_v[0] !== 1'b1) begin
            bad++;
            $display("FAIL settle_ignore: got drv=%0d freq=%0d busy=%0d want 1 100000 1",
                     drv_v[0], freq_v[0], busy_v[0]);
        end
        pulse_check(0, pw_peak(m_freq), "first_sample");
        total++;
        if (freq_v[0] !== 20'd101000) begin
            bad++;
            $display("FAIL first_step: got freq=%0d want 101000", freq_v[0]);
        end
        en_v[0] = 1'b0;
    endtask

    task automatic test_track();
        int n_dec;
        do_reset();
        model_reset(100000);
        en_v[1] = 1'b1;
        n_dec = 0;
        while (m_axis == 0 && n_dec < 40) begin
            wait_meas(1, "track_wait");
            pulse_check(1, pw_peak(m_freq), "track_step");
            n_dec++;
        end
        total++;
        if (n_dec != 16 || freq_v[1] !== 20'd111000 || l_v[1] !== 12'd490 || axis_v[1] !== 1'b1) begin
            bad++;
            $display("FAIL track_converge: got decisions=%0d freq=%0d l=%0d axis=%0d want 16 111000 490 1",
                     n_dec, freq_v[1], l_v[1], axis_v[1]);
        end
    endtask

    task automatic test_clamp();
        int exp_seq[4] = '{149000, 150000, 150000, 149000};
        int got_seq[4];
        int ok;
        do_reset();
        model_reset(148000);
        en_v[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_meas(2, "clamp_wait");
            pulse_check(2, m_freq / 100, "clamp_step");
            got_seq[k] = int'(freq_v[2]);
        end
        ok = 1;
        for (int k = 0; k < 4; k++) if (got_seq[k] != exp_seq[k]) ok = 0;
        total++;
        if (ok != 1) begin
            bad++;
            $display("FAIL clamp_seq: got %0d %0d %0d %0d want 149000 150000 150000 149000",
                     got_seq[0], got_seq[1], got_seq[2], got_seq[3]);
        end
        en_v[2] = 1'b0;
    endtask

    task automatic test_lock();
        int seq[12] = '{1000, 900, 1000, 900, 1000, 900, 2000, 1900, 1950, 1800, 1900, 1500};
        do_reset();
        total++;
        if (freq_v[1] !== 20'd100000 || l_v[1] !== 12'd480 || axis_v[1] !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: got freq=%0d l=%0d axis=%0d want 100000 480 0",
                     freq_v[1], l_v[1], axis_v[1]);
        end
        model_reset(100000);
        en_v[1] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            wait_meas(1, "lock_wait");
            pulse_check(1, seq[k], "lock_step");
        end
        total++;
        if (locked_v[1] !== 1'b1 || busy_v[1] !== 1'b0) begin
            bad++;
            $display("FAIL lock_enter: got locked=%0d busy=%0d want 1 0", locked_v[1], busy_v[1]);
        end
        repeat (5) tick();
        pulse_locked(1, 1437, "lock_hold_1437");
        pulse_locked(1, 1436, "lock_hold_1436");
        pulse_locked(1, 1435, "lock_drop_1435");
        total++;
        if (locked_v[1] !== 1'b0 || axis_v[1] !== 1'b0 || busy_v[1] !== 1'b1) begin
            bad++;
            $display("FAIL lock_drop: got locked=%0d axis=%0d busy=%0d want 0 0 1",
                     locked_v[1], axis_v[1], busy_v[1]);
        end
        pulse_check(1, 100, "retrack_measure");
        pend = 0;
    endtask

    task automatic test_en_drop();
        int n;
        do_reset();
        model_reset(100000);
        en_v[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_meas(1, "drop_wait");
            pulse_check(1, 100 * (k + 1), "drop_climb");
        end
        n = 0;
        while (drv_v[1] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        repeat (10) tick();
        en_v[1] = 1'b0;
        model_en_drop();
        tick();
        total++;
        if (drv_v[1] !== 1'b0 || freq_v[1] !== 20'd105000 || busy_v[1] !== 1'b0 || axis_v[1] !== 1'b0) begin
            bad++;
            $display("FAIL en_drop: got drv=%0d freq=%0d busy=%0d axis=%0d want 0 105000 0 0",
                     drv_v[1], freq_v[1], busy_v[1], axis_v[1]);
        end
        repeat (3) tick();
        en_v[1] = 1'b1;
        tick();
        total++;
        if (drv_v[1] !== 1'b0 || freq_v[1] !== 20'd105000 || busy_v[1] !== 1'b1) begin
            bad++;
            $display("FAIL re_enable: got drv=%0d freq=%0d busy=%0d want 0 105000 1",
                     drv_v[1], freq_v[1], busy_v[1]);
        end
        wait_meas(1, "reen_wait");
        pulse_check(1, 5, "reen_first");
        total++;
        if (freq_v[1] !== 20'd106000) begin
            bad++;
            $display("FAIL reen_step: got freq=%0d want 106000", freq_v[1]);
        end
    endtask

    task automatic test_random();
        int s;
        do_reset();
        model_reset(100000);
        en_v[1] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (m_locked != 0) begin
                s = int'($urandom_range(m_lockp + 20, (m_lockp > 150) ? m_lockp - 150 : 0));
                pulse_locked(1, s, "rand_locked");
            end else begin
                if (pend == 0) wait_meas(1, "rand_wait");
                pend = 0;
                s = int'($urandom_range(1600, 400));
                pulse_check(1, s, "rand_decide");
            end
        end
    endtask

    initial begin
        nrst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en_v[i] = 1'b0; mv_v[i] = 1'b0; mp_v[i] = 16'd0;
        end
        pend = 0;
        test_reset();
        test_apply_settle();
        test_track();
        test_clamp();
        test_lock();
        test_en_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
